// File: rtl/cpu_defs.sv
// Definitions shared between the instruction feeder and the control unit.
// Opcodes, instruction-register field positions and time-step width.
package cpu_defs;

  localparam int IR_W   = 9;
  localparam int STEP_W = 2;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;

  localparam logic [2:0] OP_MVI  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_MV   = 3'b111;

  function automatic logic [2:0] ir_opcode(
    input logic [IR_W-1:0] ir
  );
    return ir[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Program-memory and control-unit bus of the instruction feeder.
// master = feeder side, slave = memory / control-unit side.
interface instr_feeder_if
  import cpu_defs::*;
#(
  parameter int ADDR_W = 8
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_rdata;
  logic [IR_W-1:0]   iin;
  logic [15:0]       imediate;
  logic [STEP_W-1:0] count;
  logic              run;
  logic              done;
  logic              halted;
  logic [15:0]       retired;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    output iin,
    output imediate,
    output count,
    output run,
    input  done,
    output halted,
    output retired
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    input  iin,
    input  imediate,
    input  count,
    input  run,
    output done,
    input  halted,
    input  retired
  );

endinterface

// File: rtl/instr_feeder.sv
// Fetches instructions from program memory and feeds the control unit,
// holding run and stepping count until done ends each instruction.
module instr_feeder
  import cpu_defs::*;
#(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  instr_feeder_if.master bus
);

  localparam logic [ADDR_W-1:0] START =
    ADDR_W'(START_ADDR);
  localparam logic [STEP_W-1:0] STEP_MAX =
    '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_I,
    S_FETCH_IMM,
    S_WAIT_IMM,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t state;
  state_t next;

  logic [ADDR_W-1:0] pc;
  logic [2:0]        op;
  logic              fetch_next;

  assign op = ir_opcode(bus.mem_rdata[IR_W-1:0]);
  assign fetch_next =
    (next == S_FETCH) || (next == S_FETCH_IMM);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:      if (start) next = S_FETCH;
      S_FETCH:     next = S_WAIT_I;
      S_WAIT_I: begin
        if (op == OP_MVI)       next = S_FETCH_IMM;
        else if (op == OP_HALT) next = S_HALTED;
        else                    next = S_EXEC;
      end
      S_FETCH_IMM: next = S_WAIT_IMM;
      S_WAIT_IMM:  next = S_EXEC;
      S_EXEC:      if (bus.done) next = S_FETCH;
      S_HALTED:    if (start) next = S_FETCH;
      default:     next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc           <= START;
      bus.mem_addr <= START;
      bus.mem_rd   <= 1'b0;
      bus.iin      <= '0;
      bus.imediate <= '0;
      bus.count    <= '0;
      bus.run      <= 1'b0;
      bus.halted   <= 1'b0;
      bus.retired  <= '0;
    end else begin
      bus.mem_rd <= fetch_next;
      bus.run    <= (next == S_EXEC);
      bus.halted <= (next == S_HALTED);
      if (fetch_next)
        bus.mem_addr <= pc;
      if (state == S_FETCH || state == S_FETCH_IMM)
        pc <= pc + 1'b1;
      // HALT never reaches the control unit, so iin keeps the last op.
      if (state == S_WAIT_I && op != OP_HALT)
        bus.iin <= bus.mem_rdata[IR_W-1:0];
      if (state == S_WAIT_IMM)
        bus.imediate <= bus.mem_rdata;
      if (state == S_EXEC && !bus.done) begin
        if (bus.count != STEP_MAX)
          bus.count <= bus.count + 1'b1;
      end else begin
        bus.count <= '0;
      end
      if (state == S_EXEC && bus.done)
        bus.retired <= bus.retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed self-checking bench for instr_feeder.
// Two instances: default geometry and a 2-bit pc starting at 3.
module tb_instr_feeder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [4];

  always #5 clock = ~clock;

  instr_feeder_if #(.ADDR_W(8)) bus0 ();
  instr_feeder_if #(.ADDR_W(2)) bus1 ();

  instr_feeder #(.ADDR_W(8), .START_ADDR(0)) dut0 (
    .clock(clock),
    .reset(reset),
    .start(start0),
    .bus(bus0.master)
  );

  instr_feeder #(.ADDR_W(2), .START_ADDR(3)) dut1 (
    .clock(clock),
    .reset(reset),
    .start(start1),
    .bus(bus1.master)
  );

  always @(posedge clock) begin
    if (bus0.mem_rd) bus0.mem_rdata <= mem0[bus0.mem_addr];
    if (bus1.mem_rd) bus1.mem_rdata <= mem1[bus1.mem_addr];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 256; i++) mem0[i] = 16'h0180;
    for (int i = 0; i < 4; i++) mem1[i] = 16'h0180;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++;
    if (bus0.run !== 1'b0 || bus0.count !== 2'd0) begin
      nerr++;
      $display("FAIL reset_run_count: run=%b count=%0d want 0/0",
               bus0.run, bus0.count);
    end
    nchk++;
    if (bus0.mem_rd !== 1'b0 || bus0.mem_addr !== 8'd0) begin
      nerr++;
      $display("FAIL reset_mem: rd=%b addr=%h want 0/00",
               bus0.mem_rd, bus0.mem_addr);
    end
    nchk++;
    if (bus0.halted !== 1'b0 || bus0.retired !== 16'd0 ||
        bus0.iin !== 9'd0 || bus0.imediate !== 16'd0) begin
      nerr++;
      $display("FAIL reset_regs: h=%b ret=%h iin=%h imm=%h want 0",
               bus0.halted, bus0.retired, bus0.iin, bus0.imediate);
    end
    nchk++;
    if (bus1.mem_addr !== 2'd3) begin
      nerr++;
      $display("FAIL reset_start_addr: addr=%0d want 3",
               bus1.mem_addr);
    end
  endtask

  task automatic test_single_halt();
    do_reset();
    mem0[0] = 16'h01C1;
    mem0[1] = 16'h0180;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    nchk++;
    if (bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 8'd0) begin
      nerr++;
      $display("FAIL single_fetch0: rd=%b addr=%h want 1/00",
               bus0.mem_rd, bus0.mem_addr);
    end
    step();
    nchk++;
    if (bus0.run !== 1'b0) begin
      nerr++;
      $display("FAIL single_c2_run: run=%b want 0", bus0.run);
    end
    step();
    nchk++;
    if (bus0.run !== 1'b1 || bus0.iin !== 9'h1C1 ||
        bus0.count !== 2'd0) begin
      nerr++;
      $display("FAIL single_c3: run=%b iin=%h cnt=%0d want 1/1c1/0",
               bus0.run, bus0.iin, bus0.count);
    end
    step();
    step();
    nchk++;
    if (bus0.count !== 2'd2) begin
      nerr++;
      $display("FAIL single_c5_count: cnt=%0d want 2", bus0.count);
    end
    bus0.done = 1'b1;
    step();
    bus0.done = 1'b0;
    nchk++;
    if (bus0.run !== 1'b0 || bus0.retired !== 16'd1 ||
        bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 8'd1) begin
      nerr++;
      $display("FAIL single_c6: run=%b ret=%0d rd=%b addr=%h want 0/1/1/01",
               bus0.run, bus0.retired, bus0.mem_rd, bus0.mem_addr);
    end
    step();
    step();
    nchk++;
    if (bus0.halted !== 1'b1 || bus0.run !== 1'b0 ||
        bus0.iin !== 9'h1C1) begin
      nerr++;
      $display("FAIL single_c8_halt: h=%b run=%b iin=%h want 1/0/1c1",
               bus0.halted, bus0.run, bus0.iin);
    end
    repeat (4) step();
    nchk++;
    if (bus0.halted !== 1'b1 || bus0.run !== 1'b0 ||
        bus0.mem_rd !== 1'b0) begin
      nerr++;
      $display("FAIL single_stay_halt: h=%b run=%b rd=%b want 1/0/0",
               bus0.halted, bus0.run, bus0.mem_rd);
    end
  endtask

  task automatic test_mvi_hold_resume();
    do_reset();
    mem0[0] = 16'h0140;
    mem0[1] = 16'hBEEF;
    mem0[2] = 16'h0180;
    mem0[3] = 16'h0009;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    nchk++;
    if (bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 8'd0) begin
      nerr++;
      $display("FAIL mvi_fetch0: rd=%b addr=%h want 1/00",
               bus0.mem_rd, bus0.mem_addr);
    end
    step();
    step();
    nchk++;
    if (bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 8'd1 ||
        bus0.run !== 1'b0) begin
      nerr++;
      $display("FAIL mvi_fetch1: rd=%b addr=%h run=%b want 1/01/0",
               bus0.mem_rd, bus0.mem_addr, bus0.run);
    end
    step();
    step();
    nchk++;
    if (bus0.run !== 1'b1 || bus0.iin !== 9'h140 ||
        bus0.imediate !== 16'hBEEF || bus0.count !== 2'd0) begin
      nerr++;
      $display("FAIL mvi_c5: run=%b iin=%h imm=%h cnt=%0d want 1/140/beef/0",
               bus0.run, bus0.iin, bus0.imediate, bus0.count);
    end
    for (int i = 1; i < 10; i++) begin
      step();
      nchk++;
      if (bus0.run !== 1'b1 ||
          bus0.count !== ((i > 3) ? 2'd3 : 2'(i))) begin
        nerr++;
        $display("FAIL hold_%0d: run=%b cnt=%0d want 1/%0d",
                 i, bus0.run, bus0.count, (i > 3) ? 3 : i);
      end
    end
    bus0.done = 1'b1;
    step();
    bus0.done = 1'b0;
    nchk++;
    if (bus0.run !== 1'b0 || bus0.count !== 2'd0 ||
        bus0.retired !== 16'd1 || bus0.mem_addr !== 8'd2) begin
      nerr++;
      $display("FAIL hold_done: run=%b cnt=%0d ret=%0d addr=%h want 0/0/1/02",
               bus0.run, bus0.count, bus0.retired, bus0.mem_addr);
    end
    step();
    step();
    nchk++;
    if (bus0.halted !== 1'b1 || bus0.imediate !== 16'hBEEF) begin
      nerr++;
      $display("FAIL mvi_halt: h=%b imm=%h want 1/beef",
               bus0.halted, bus0.imediate);
    end
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    nchk++;
    if (bus0.halted !== 1'b0 || bus0.mem_rd !== 1'b1 ||
        bus0.mem_addr !== 8'd3) begin
      nerr++;
      $display("FAIL resume_fetch: h=%b rd=%b addr=%h want 0/1/03",
               bus0.halted, bus0.mem_rd, bus0.mem_addr);
    end
    step();
    step();
    nchk++;
    if (bus0.run !== 1'b1 || bus0.iin !== 9'h009 ||
        bus0.imediate !== 16'hBEEF) begin
      nerr++;
      $display("FAIL resume_exec: run=%b iin=%h imm=%h want 1/009/beef",
               bus0.run, bus0.iin, bus0.imediate);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem1[3] = 16'h0140;
    mem1[0] = 16'h1234;
    mem1[1] = 16'h01C1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    nchk++;
    if (bus1.mem_rd !== 1'b1 || bus1.mem_addr !== 2'd3) begin
      nerr++;
      $display("FAIL wrap_fetch3: rd=%b addr=%0d want 1/3",
               bus1.mem_rd, bus1.mem_addr);
    end
    step();
    step();
    nchk++;
    if (bus1.mem_rd !== 1'b1 || bus1.mem_addr !== 2'd0) begin
      nerr++;
      $display("FAIL wrap_imm_addr: rd=%b addr=%0d want 1/0",
               bus1.mem_rd, bus1.mem_addr);
    end
    step();
    step();
    nchk++;
    if (bus1.run !== 1'b1 || bus1.imediate !== 16'h1234) begin
      nerr++;
      $display("FAIL wrap_imm: run=%b imm=%h want 1/1234",
               bus1.run, bus1.imediate);
    end
    bus1.done = 1'b1;
    step();
    bus1.done = 1'b0;
    nchk++;
    if (bus1.mem_rd !== 1'b1 || bus1.mem_addr !== 2'd1) begin
      nerr++;
      $display("FAIL wrap_next_pc: rd=%b addr=%0d want 1/1",
               bus1.mem_rd, bus1.mem_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem0[0] = 16'h01C1;
    mem0[1] = 16'h0008;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    step();
    bus0.done = 1'b1;
    step();
    bus0.done = 1'b0;
    nchk++;
    if (bus0.retired !== 16'd1 || bus0.run !== 1'b0) begin
      nerr++;
      $display("FAIL done_at_zero: ret=%0d run=%b want 1/0",
               bus0.retired, bus0.run);
    end
    step();
    step();
    step();
    nchk++;
    if (bus0.run !== 1'b1 || bus0.count !== 2'd1 ||
        bus0.iin !== 9'h008) begin
      nerr++;
      $display("FAIL mid_c7: run=%b cnt=%0d iin=%h want 1/1/008",
               bus0.run, bus0.count, bus0.iin);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    nchk++;
    if (bus0.run !== 1'b0 || bus0.count !== 2'd0 ||
        bus0.retired !== 16'd0 || bus0.mem_rd !== 1'b0 ||
        bus0.mem_addr !== 8'd0) begin
      nerr++;
      $display("FAIL mid_reset: run=%b cnt=%0d ret=%0d rd=%b addr=%h want 0",
               bus0.run, bus0.count, bus0.retired,
               bus0.mem_rd, bus0.mem_addr);
    end
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    nchk++;
    if (bus0.mem_rd !== 1'b1 || bus0.mem_addr !== 8'd0) begin
      nerr++;
      $display("FAIL mid_restart: rd=%b addr=%h want 1/00",
               bus0.mem_rd, bus0.mem_addr);
    end
    step();
    step();
    nchk++;
    if (bus0.run !== 1'b1 || bus0.iin !== 9'h1C1) begin
      nerr++;
      $display("FAIL mid_rerun: run=%b iin=%h want 1/1c1",
               bus0.run, bus0.iin);
    end
  endtask

  task automatic test_ignore();
    do_reset();
    mem0[0] = 16'h01C1;
    bus0.done = 1'b1;
    step();
    step();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    bus0.done = 1'b0;
    step();
    nchk++;
    if (bus0.retired !== 16'd0 || bus0.run !== 1'b1 ||
        bus0.count !== 2'd0) begin
      nerr++;
      $display("FAIL ignore_done: ret=%0d run=%b cnt=%0d want 0/1/0",
               bus0.retired, bus0.run, bus0.count);
    end
    start0 = 1'b1;
    step();
    step();
    start0 = 1'b0;
    nchk++;
    if (bus0.run !== 1'b1 || bus0.count !== 2'd2 ||
        bus0.mem_rd !== 1'b0) begin
      nerr++;
      $display("FAIL ignore_start: run=%b cnt=%0d rd=%b want 1/2/0",
               bus0.run, bus0.count, bus0.mem_rd);
    end
    bus0.done = 1'b1;
    step();
    bus0.done = 1'b0;
    nchk++;
    if (bus0.retired !== 16'd1 || bus0.mem_addr !== 8'd1 ||
        bus0.mem_rd !== 1'b1) begin
      nerr++;
      $display("FAIL ignore_retire: ret=%0d addr=%h rd=%b want 1/01/1",
               bus0.retired, bus0.mem_addr, bus0.mem_rd);
    end
  endtask

  initial begin
    bus0.done = 1'b0;
    bus1.done = 1'b0;
    bus0.mem_rdata = '0;
    bus1.mem_rdata = '0;
    test_reset();
    test_single_halt();
    test_mvi_hold_resume();
    test_wrap();
    test_reset_mid();
    test_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nchk, nerr);
    $finish;
  end

endmodule
